// File: rtl/mdu_if.sv
// Command/result bundle between the EX stage and the HI/LO multiply/divide sequencer.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs, rt, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative MULT/DIV sequencer owning HI/LO; one bit per cycle, sign fix in FIX.
// Optional MDU_DIVZERO_FAST_EN: divide by zero skips straight to FIX.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  mdu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dz_q, dz_d;
  logic               div_q, div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic is_mul, is_div, is_mthi, is_mtlo, is_sgn;
  logic a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign is_mul  = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign is_div  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign is_mthi = (bus.op == OP_MTHI);
  assign is_mtlo = (bus.op == OP_MTLO);
  assign is_sgn  = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign a_neg   = is_sgn & bus.rs[WIDTH-1];
  assign b_neg   = is_sgn & bus.rt[WIDTH-1];
  assign a_abs   = a_neg ? -bus.rs : bus.rs;
  assign b_abs   = b_neg ? -bus.rt : bus.rt;
  assign b_zero  = (bus.rt == '0);

  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rsh;
  logic               geq;
  logic [WIDTH-1:0]   rdiff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   remv;

  assign msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  // Partial remainder is WIDTH+1 wide; the difference always fits WIDTH.
  assign rsh   = {rem_q, acc_q[WIDTH-1]};
  assign geq   = rsh >= {1'b0, b_q};
  assign rdiff = rsh[WIDTH-1:0] - b_q;
  assign prod  = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo   = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign remv  = sa_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            unique case (1'b1)
              is_mthi: hi_d = bus.rs;
              is_mtlo: lo_d = bus.rs;
              is_mul, is_div: begin
                acc_d   = {{WIDTH{1'b0}}, a_abs};
                rem_d   = '0;
                b_d     = b_abs;
                sa_d    = a_neg;
                sb_d    = b_neg;
                dz_d    = is_div & b_zero;
                div_d   = is_div;
                cnt_d   = CW'(WIDTH);
                state_d = is_div ? DIV : MUL;
`ifdef MDU_DIVZERO_FAST_EN
                if (is_div && b_zero) begin
                  rem_d   = a_abs;
                  state_d = FIX;
                end
`endif
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc_d = {msum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
        DIV: begin
          acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], geq};
          rem_d = geq ? rdiff : rsh[WIDTH-1:0];
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
        FIX: begin
          // Divide by zero leaves rem = |rs|, so the sign fix restores rs.
          if (div_q) begin
            hi_d = remv;
            lo_d = dz_q ? '1 : quo;
          end else begin
            {hi_d, lo_d} = prod;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed-vector bench for mdu_seq: arithmetic results, latency, MTHI/MTLO,
// start-while-busy, flush and mid-operation reset.
module tb_mdu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

`ifdef MDU_DIVZERO_FAST_EN
  localparam int DZ_BUSY = 1;
`else
  localparam int DZ_BUSY = 33;
`endif

  mdu_if #(.WIDTH(32)) bus();

  mdu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          noise;
    int          bz;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit noise,
                        output int bcnt, output int dcnt,
                        output logic dend);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.rs    = a;
    bus.rt    = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bcnt = 0;
    dcnt = 0;
    while (bus.busy && bcnt < 200) begin
      bcnt++;
      if (bus.done) dcnt++;
      if (noise) begin
        bus.start = (bcnt > 2 && bcnt < 20);
        bus.op    = 3'd5;
        bus.rs    = 32'hDEADBEEF;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.op    = 3'd0;
    dend = bus.done;
    if (dend) dcnt++;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
    else n_pass++;
    n_chk++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
    else n_pass++;
    n_chk++;
    if (bus.hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", bus.hi);
    else n_pass++;
    n_chk++;
    if (bus.lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", bus.lo);
    else n_pass++;
    n_chk++;
    rst_n = 1'b1;
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.rs    = 32'h12345678;
    @(posedge clk); #1;
    if (bus.hi !== 32'h12345678) $display("FAIL mthi_hi: got %h want 12345678", bus.hi);
    else n_pass++;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL mthi_busy_done: got %b%b want 00", bus.busy, bus.done);
    else n_pass++;
    n_chk++;
    bus.op = 3'd6;
    bus.rs = 32'h9ABCDEF0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    if (bus.lo !== 32'h9ABCDEF0) $display("FAIL mtlo_lo: got %h want 9abcdef0", bus.lo);
    else n_pass++;
    n_chk++;
    if (bus.hi !== 32'h12345678) $display("FAIL mtlo_hi_kept: got %h want 12345678", bus.hi);
    else n_pass++;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL mtlo_busy_done: got %b%b want 00", bus.busy, bus.done);
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_arith();
    vec_t v[8];
    int   bcnt, dcnt;
    logic dend;
    v[0] = '{3'd1, 32'hFFFFFFFD, 32'd5,        1'b0, 33, 32'hFFFFFFFF, 32'hFFFFFFF1};
    v[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33, 32'hFFFFFFFE, 32'h00000001};
    v[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        1'b0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[3] = '{3'd4, 32'd100,      32'd7,        1'b0, 33, 32'd2,        32'd14};
    v[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 33, 32'h0,        32'h80000000};
    v[5] = '{3'd4, 32'h55,       32'h0,        1'b0, DZ_BUSY, 32'h55,  32'hFFFFFFFF};
    v[6] = '{3'd3, 32'hFFFFFFF9, 32'h0,        1'b0, DZ_BUSY, 32'hFFFFFFF9, 32'hFFFFFFFF};
    v[7] = '{3'd1, 32'h80000000, 32'h80000000, 1'b0, 33, 32'h40000000, 32'h0};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].noise, bcnt, dcnt, dend);
      if (bcnt != v[i].bz)
        $display("FAIL arith%0d_busy: got %0d cycles want %0d", i, bcnt, v[i].bz);
      else n_pass++;
      n_chk++;
      if (dcnt != 1) $display("FAIL arith%0d_done_count: got %0d want 1", i, dcnt);
      else n_pass++;
      n_chk++;
      if (dend !== 1'b1) $display("FAIL arith%0d_done_at_end: got %b want 1", i, dend);
      else n_pass++;
      n_chk++;
      if (bus.hi !== v[i].hi) $display("FAIL arith%0d_hi: got %h want %h", i, bus.hi, v[i].hi);
      else n_pass++;
      n_chk++;
      if (bus.lo !== v[i].lo) $display("FAIL arith%0d_lo: got %h want %h", i, bus.lo, v[i].lo);
      else n_pass++;
      n_chk++;
    end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.rs    = 32'hAAAA0000;
    @(negedge clk);
    bus.op    = 3'd6;
    bus.rs    = 32'h0000BBBB;
    @(negedge clk);
    bus.op    = 3'd4;
    bus.rs    = 32'd10;
    bus.rt    = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    if (bus.busy !== 1'b1) $display("FAIL flush_pre_busy: got %b want 1", bus.busy);
    else n_pass++;
    n_chk++;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    if (bus.busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", bus.busy);
    else n_pass++;
    n_chk++;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.busy || bus.done) seen++;
    end
    if (seen != 0) $display("FAIL flush_quiet: got %0d busy/done cycles want 0", seen);
    else n_pass++;
    n_chk++;
    if (bus.hi !== 32'hAAAA0000) $display("FAIL flush_hi: got %h want aaaa0000", bus.hi);
    else n_pass++;
    n_chk++;
    if (bus.lo !== 32'h0000BBBB) $display("FAIL flush_lo: got %h want 0000bbbb", bus.lo);
    else n_pass++;
    n_chk++;
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 3'd1;
    bus.rs    = 32'd6;
    bus.rt    = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 3'd0;
    if (bus.busy !== 1'b0) $display("FAIL flush_start_busy: got %b want 0", bus.busy);
    else n_pass++;
    n_chk++;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.rs    = 32'd10;
    bus.rt    = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL midrst_busy_done: got %b%b want 00", bus.busy, bus.done);
    else n_pass++;
    n_chk++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0)
      $display("FAIL midrst_hilo: got %h_%h want 0_0", bus.hi, bus.lo);
    else n_pass++;
    n_chk++;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.busy || bus.done) seen++;
    end
    if (seen != 0) $display("FAIL midrst_quiet: got %0d busy/done cycles want 0", seen);
    else n_pass++;
    n_chk++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.rs    = 32'h0;
    bus.rt    = 32'h0;
    bus.flush = 1'b0;
    test_reset();
    test_mthi_mtlo();
    test_arith();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the EX stage and runs a one-bit-per-cycle shift-add or restoring-divide datapath. It drives a busy stall to the pipeline controller and presents HI/LO for MFHI/MFLO forwarding.

Parameters:
WIDTH, 32, operand and HI/LO width; iterative latency is WIDTH+1 cycles.

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  command valid; sampled only when busy=0
op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
rs  in  WIDTH  operand A (multiplicand/dividend; MTHI/MTLO source)
rt  in  WIDTH  operand B (multiplier/divisor)
flush  in  1  abort in-flight operation (exception/branch squash)
busy  out  1  iterative operation in flight; stalls pipeline
done  out  1  one-cycle pulse: HI/LO just updated by MULT*/DIV*
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0 at edge): state IDLE, hi=lo=0, busy=0, done=0, iteration counter=0, internal accumulators cleared. Reset mid-operation discards the operation.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE, start=1, flush=0:
  - MTHI/MTLO: hi/lo <= rs at that edge; busy stays 0; no done pulse.
  - MULT*/DIV*: latch |rs|, |rt| (signed ops) or raw values (unsigned ops), plus the sign bits. Counter <= WIDTH. Go to MUL or DIV. busy=1 from the next cycle.
  - NOP/reserved: no effect.
- start while busy=1 is ignored. The pipeline must hold the instruction.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit product accumulator. Counter decrements. At counter==1, go to FIX.
- DIV: restoring divide, one quotient bit per cycle, WIDTH+1-bit partial remainder. At counter==1, go to FIX.
- FIX, one cycle, sign correction:
  - Signed MULT: negate the product if the operand signs differ.
  - Signed DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Result write: {hi,lo} <= product for MULT*; lo <= quotient, hi <= remainder for DIV*.
  - done=1 for the following cycle, busy=0, return to IDLE.
- Latency: command accepted at edge E0; busy high E0..E(WIDTH+1); hi/lo valid and done high after edge E(WIDTH+1). For WIDTH=32, busy is high for 33 cycles.
- Divide by zero (rt=0, DIV or DIVU): full latency; lo=all ones, hi=rs (original, no sign fix); done pulses normally.
- Signed overflow case 0x80000000 / -1: lo=0x80000000, hi=0. Falls out of magnitude arithmetic with wrap; no trap.
- flush=1: in any state, go to IDLE at that edge; busy=0 next cycle; hi/lo keep their pre-command values; no done. flush together with start in IDLE: flush wins, command dropped. flush during the FIX cycle also suppresses the write.
- hi/lo change only on MTHI/MTLO in IDLE or on FIX completion.

Optional Feature:
Macro MDU_DIVZERO_FAST_EN.
- Defined: DIV/DIVU with rt=0 is detected at acceptance. FSM goes directly to FIX (busy high 1 cycle). Results are the same (lo=all ones, hi=rs), and done pulses after 2 edges total.
- Undefined: divide-by-zero runs the full WIDTH+1-cycle sequence with those results.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy 33 cycles, done once, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; start pulses during busy ignored, result unchanged.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100, rt=7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 on consecutive cycles -> hi/lo updated next edge, busy never asserted, no done.
- Preload hi=0xAAAA0000; DIVU 10/3, flush at cycle 10 -> busy drops next cycle, no done, hi=0xAAAA0000 unchanged. Repeat with rst_n=0 mid-op -> all outputs 0.
- DIVU rs=0x55, rt=0 -> lo=0xFFFFFFFF, hi=0x55. busy 33 cycles without MDU_DIVZERO_FAST_EN, 1 cycle with it.
